msrh_credit_return_master: RTL and testbench
============================================

// Module: msrh_credit_return_master
// PURPOSE
//  Dispatch-side (credit-consumer) end of the credit/return protocol used by the LSU queues (LDQ/STQ).
//  Holds the free-entry count for one queue and grants or stalls dispatch groups against it.
//  Absorbs returns (completed/dead entries, ignored dispatches) and runs a flush-drain sequence.
//  Sits in the dispatch stage, one instance per credit-managed queue.
// PARAMETERS
//  MAX_CREDITS  16  queue depth; credit count at reset (LDQ_SIZE/STQ_SIZE)
//  MAX_REQ      4   max credits consumed per cycle (MEM_DISP_SIZE); MAX_REQ <= MAX_CREDITS
//  CW           $clog2(MAX_CREDITS)+1  derived; width of every count port
// PORTS
//  i_clk         in   1   clock
//  i_reset_n     in   1   reset, asynchronous, active-low
//  i_get_credit  in   1   dispatch group requests credits this cycle
//  i_credit_val  in   CW  credits requested (0..MAX_REQ)
//  o_no_credits  out  1   request refused; dispatch must stall, nothing consumed
//  o_credits     out  CW  registered current free-credit count
//  i_return      in   1   slave returns credits this cycle
//  i_return_val  in   CW  number of credits returned
//  i_flush       in   1   pipeline flush; enter drain
//  o_drained     out  1   r_credits == MAX_CREDITS (queue empty)
//  o_err         out  1   sticky protocol error (overflow / bad request)
// BEHAVIOUR
//  - Reset: r_credits=MAX_CREDITS, state=RUN, o_err=0 -> o_credits=MAX_CREDITS, o_drained=1, o_no_credits=0.
//  - w_ret   = i_return ? i_return_val : 0.
//  - w_avail = r_credits (+ w_ret only when bypass is enabled, see CONFIGURATION).
//  - Grant (combinational): w_grant = i_get_credit & state==RUN & !i_flush & (i_credit_val <= w_avail).
//  - o_no_credits = i_get_credit & !w_grant. It is zero when i_get_credit=0.
//  - i_credit_val==0 with i_get_credit=1 is granted and consumes nothing.
//  - Next value: r_credits' = r_credits + w_ret - (w_grant ? i_credit_val : 0).
//    Compute in CW+1 bits. Latency: return and consume are both visible on o_credits 1 cycle later.
//  - Simultaneous return and grant in the same cycle: both applied in the same update.
//  - Overflow: if r_credits' > MAX_CREDITS, clamp to MAX_CREDITS and set o_err.
//  - i_get_credit with i_credit_val > MAX_REQ: refused (o_no_credits=1) and sets o_err.
//  - o_err stays set until reset.
//  - Underflow cannot occur, because a grant requires i_credit_val <= w_avail.
//  - FSM:
//    - RUN   --i_flush--> DRAIN. A flush in the same cycle as a request refuses the request.
//    - DRAIN --r_credits'==MAX_CREDITS--> RUN. While in DRAIN every request is refused; returns are still absorbed.
//    - i_flush while already in DRAIN: stays in DRAIN.
//    - i_flush while r_credits'==MAX_CREDITS: go directly to RUN (at most one DRAIN cycle).
//  - o_drained = (r_credits == MAX_CREDITS), registered-level output, independent of state.
//  - Reset mid-operation: immediate asynchronous return to reset values; any in-flight return is lost.
// CONFIGURATION
//  - MSRH_CREDIT_RET_BYPASS_EN defined:
//    - w_avail = min(r_credits + w_ret, MAX_CREDITS).
//    - Credits returned this cycle may be granted in the same cycle.
//  - Not defined:
//    - w_avail = r_credits.
//    - Returned credits become grantable the next cycle (shorter timing path).
//  - The r_credits update rule is identical in both cases.
// TESTING
//  - Reset then request 4 each cycle, no returns (MAX_CREDITS=16):
//    - 4 grants; o_credits 16->12->8->4->0.
//    - 5th request gets o_no_credits=1 and o_credits stays 0.
//  - o_credits=2, request 3 with return 2 in the same cycle:
//    - bypass off: refused, o_credits->4.
//    - bypass on: granted, o_credits->1.
//  - o_credits=10, request 2 and return 3 together: granted, o_credits->11 next cycle.
//  - o_credits=6, i_flush with request 1:
//    - refused; state DRAIN.
//    - returns 4 then 6: o_credits 10 then 16, then back in RUN, o_drained=1.
//    - next request 4 granted.
//  - o_credits=15, return 3: o_credits clamps to 16, o_err=1 and stays 1.
//  - Request i_credit_val=5 (MAX_REQ=4): o_no_credits=1, o_err=1, o_credits unchanged.
//  - Reset asserted mid-DRAIN: outputs return to reset values immediately.

Source files
------------

// File: rtl/msrh_credit_return_master.sv
// Dispatch-side credit counter for one LSU queue: grants/stalls dispatch groups, absorbs returns, drains on flush.
// Optional MSRH_CREDIT_RET_BYPASS_EN: credits returned this cycle are grantable in the same cycle.
module msrh_credit_return_master #(
    parameter int unsigned MAX_CREDITS = 16,
    parameter int unsigned MAX_REQ     = 4,
    localparam int unsigned CW         = $clog2(MAX_CREDITS) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_get_credit,
    input  logic [CW-1:0] i_credit_val,
    output logic          o_no_credits,
    output logic [CW-1:0] o_credits,
    input  logic          i_return,
    input  logic [CW-1:0] i_return_val,
    input  logic          i_flush,
    output logic          o_drained,
    output logic          o_err
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    localparam logic [CW:0]   MAX_W     = (CW + 1)'(MAX_CREDITS);
    localparam logic [CW:0]   MAX_REQ_W = (CW + 1)'(MAX_REQ);
    localparam logic [CW-1:0] MAX_C     = CW'(MAX_CREDITS);

    state_e        state_q, state_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    logic [CW:0]   ret_w;
    logic [CW:0]   sum_ret;
    logic [CW:0]   avail;
    logic [CW:0]   req_w;
    logic [CW:0]   consume;
    logic [CW:0]   raw_next;
    logic          bad_req;
    logic          grant;
    logic          overflow;

    // One extra bit of headroom so an over-return is detectable before clamping.
    always_comb begin
        ret_w   = i_return ? {1'b0, i_return_val} : '0;
        sum_ret = {1'b0, credits_q} + ret_w;
`ifdef MSRH_CREDIT_RET_BYPASS_EN
        avail   = (sum_ret > MAX_W) ? MAX_W : sum_ret;
`else
        avail   = {1'b0, credits_q};
`endif
        req_w   = {1'b0, i_credit_val};
        bad_req = i_get_credit & (req_w > MAX_REQ_W);
        grant   = i_get_credit & (state_q == ST_RUN) & ~i_flush & ~bad_req & (req_w <= avail);
        consume = grant ? req_w : '0;
        // consume <= avail <= sum_ret, so this never wraps
        raw_next = sum_ret - consume;
        overflow = (raw_next > MAX_W);
        credits_d = overflow ? MAX_C : raw_next[CW-1:0];
        err_d     = err_q | overflow | bad_req;
    end

    always_comb begin
        state_d = state_q;
        if (i_flush || (state_q == ST_DRAIN)) begin
            state_d = (credits_d == MAX_C) ? ST_RUN : ST_DRAIN;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_RUN;
            credits_q <= MAX_C;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign o_no_credits = i_get_credit & ~grant;
    assign o_credits    = credits_q;
    assign o_drained    = (credits_q == MAX_C);
    assign o_err        = err_q;

endmodule

// File: tb/tb_msrh_credit_return_master.sv
// Self-checking bench for msrh_credit_return_master: directed scenarios then random traffic
// against an integer-level model of the credit rules.
module tb_msrh_credit_return_master;

    localparam int MAXC = 16;
    localparam int MAXR = 4;
    localparam int CW   = 5;
`ifdef MSRH_CREDIT_RET_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_get_credit;
    logic [CW-1:0] i_credit_val;
    logic          o_no_credits;
    logic [CW-1:0] o_credits;
    logic          i_return;
    logic [CW-1:0] i_return_val;
    logic          i_flush;
    logic          o_drained;
    logic          o_err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_credits;
    bit m_drain;
    bit m_err;

    always #5 i_clk = ~i_clk;

    msrh_credit_return_master #(
        .MAX_CREDITS(MAXC),
        .MAX_REQ    (MAXR)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_get_credit(i_get_credit),
        .i_credit_val(i_credit_val),
        .o_no_credits(o_no_credits),
        .o_credits   (o_credits),
        .i_return    (i_return),
        .i_return_val(i_return_val),
        .i_flush     (i_flush),
        .o_drained   (o_drained),
        .o_err       (o_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credits = MAXC;
        m_drain   = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_credits"}, 32'(o_credits), 32'(m_credits));
        check({tag, "_drained"}, 32'(o_drained), 32'(m_credits == MAXC));
        check({tag, "_err"},     32'(o_err),     32'(m_err));
    endtask

    // Drives one cycle (called just after a rising edge), checks the stall output
    // mid-cycle and the registered outputs after the next edge.
    task automatic cycle(input string tag, input bit get, input int val,
                         input bit r, input int rv, input bit fl);
        int ret, avail, nxt;
        bit bad, grant;
        i_get_credit = get;
        i_credit_val = CW'(val);
        i_return     = r;
        i_return_val = CW'(rv);
        i_flush      = fl;
        #3;
        ret   = r ? rv : 0;
        avail = BYP ? ((m_credits + ret > MAXC) ? MAXC : m_credits + ret) : m_credits;
        bad   = get && (val > MAXR);
        grant = get && !m_drain && !fl && !bad && (val <= avail);
        check({tag, "_nocred"}, 32'(o_no_credits), 32'(get && !grant));
        nxt = m_credits + ret - (grant ? val : 0);
        if (nxt > MAXC) begin
            nxt   = MAXC;
            m_err = 1'b1;
        end
        if (bad) m_err = 1'b1;
        if (fl || m_drain) m_drain = (nxt != MAXC);
        m_credits = nxt;
        @(posedge i_clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_get_credit = 1'b0;
        i_credit_val = '0;
        i_return     = 1'b0;
        i_return_val = '0;
        i_flush      = 1'b0;
        model_reset();
        #12;
        check("rst_credits", 32'(o_credits), 32'(MAXC));
        check("rst_drained", 32'(o_drained), 32'd1);
        check("rst_err",     32'(o_err),     32'd0);
        check("rst_nocred",  32'(o_no_credits), 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Drain all credits 4 at a time, then one refused request
        for (int k = 0; k < 4; k++) cycle("req4", 1'b1, 4, 1'b0, 0, 1'b0);
        check("empty_credits", 32'(o_credits), 32'd0);
        cycle("req4_empty", 1'b1, 4, 1'b0, 0, 1'b0);
        cycle("zero_req", 1'b1, 0, 1'b0, 0, 1'b0);

        // Same-cycle return vs request at the edge of availability
        cycle("ret2", 1'b0, 0, 1'b1, 2, 1'b0);
        cycle("bypass", 1'b1, 3, 1'b1, 2, 1'b0);
        check("bypass_result", 32'(o_credits), BYP ? 32'd1 : 32'd4);

        // Simultaneous grant and return
        cycle("to10", 1'b0, 0, 1'b1, 10 - m_credits, 1'b0);
        cycle("req2_ret3", 1'b1, 2, 1'b1, 3, 1'b0);
        check("req2_ret3_val", 32'(o_credits), 32'd11);

        // Flush and drain
        cycle("to7", 1'b1, 4, 1'b0, 0, 1'b0);
        cycle("to6", 1'b1, 1, 1'b0, 0, 1'b0);
        cycle("flush_req", 1'b1, 1, 1'b0, 0, 1'b1);
        cycle("drain_ret4", 1'b1, 1, 1'b1, 4, 1'b0);
        cycle("drain_ret6", 1'b0, 0, 1'b1, 6, 1'b0);
        cycle("post_drain", 1'b1, 4, 1'b0, 0, 1'b0);
        check("post_drain_val", 32'(o_credits), 32'd12);

        // Overflow clamp and sticky error
        cycle("ret3a", 1'b0, 0, 1'b1, 3, 1'b0);
        cycle("ovf", 1'b0, 0, 1'b1, 3, 1'b0);
        check("ovf_err", 32'(o_err), 32'd1);
        cycle("idle", 1'b0, 0, 1'b0, 0, 1'b0);

        // Oversized request
        cycle("req5", 1'b1, 5, 1'b0, 0, 1'b0);
        cycle("flush_full", 1'b0, 0, 1'b0, 0, 1'b1);
        cycle("full_run", 1'b1, 4, 1'b0, 0, 1'b0);

        // Asynchronous reset in the middle of a drain
        cycle("pre_flush", 1'b1, 4, 1'b0, 0, 1'b0);
        cycle("flush", 1'b0, 0, 1'b0, 0, 1'b1);
        i_return     = 1'b1;
        i_return_val = CW'(2);
        i_reset_n    = 1'b0;
        #1;
        model_reset();
        check("arst_credits", 32'(o_credits), 32'(MAXC));
        check("arst_drained", 32'(o_drained), 32'd1);
        check("arst_err",     32'(o_err),     32'd0);
        i_return     = 1'b0;
        i_return_val = '0;
        #2;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;
        check_regs("arst_rel");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int v, rv;
            bit g, r, f;
            g  = ($urandom % 4) != 0;
            v  = (($urandom % 16) == 0) ? int'($urandom_range(5, 6)) : int'($urandom_range(0, MAXR));
            r  = ($urandom % 2) != 0;
            rv = (($urandom % 32) == 0) ? int'($urandom_range(0, MAXC - m_credits + 3))
                                        : int'($urandom_range(0, MAXC - m_credits));
            f  = ($urandom % 20) == 0;
            cycle("rand", g, v, r, rv, f);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
